// File: rtl/naive_bus_arbiter2.sv
// Two-master to one-slave naive_bus arbiter: fixed priority m0 > m1 with an m1
// starvation guard, or round-robin when NAIVE_ARB_RR_EN is defined.
module naive_bus_arbiter2 #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_rd_req,
  input  logic        m1_rd_req,
  output logic        m0_rd_gnt,
  output logic        m1_rd_gnt,
  input  logic [31:0] m0_rd_addr,
  input  logic [31:0] m1_rd_addr,
  output logic [31:0] m0_rd_data,
  output logic [31:0] m1_rd_data,
  input  logic        m0_wr_req,
  input  logic        m1_wr_req,
  output logic        m0_wr_gnt,
  output logic        m1_wr_gnt,
  input  logic [31:0] m0_wr_addr,
  input  logic [31:0] m1_wr_addr,
  input  logic [3:0]  m0_wr_byte,
  input  logic [3:0]  m1_wr_byte,
  input  logic [31:0] m0_wr_data,
  input  logic [31:0] m1_wr_data,
  output logic        s_rd_req,
  output logic        s_wr_req,
  input  logic        s_rd_gnt,
  input  logic        s_wr_gnt,
  output logic [31:0] s_rd_addr,
  output logic [31:0] s_wr_addr,
  output logic [3:0]  s_wr_byte,
  output logic [31:0] s_wr_data,
  input  logic [31:0] s_rd_data
);

  typedef enum logic [1:0] {
    HOLD_NONE = 2'd0,
    HOLD_M0   = 2'd1,
    HOLD_M1   = 2'd2
  } hold_state_e;

  hold_state_e hold_q, hold_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_owner_q, rd_owner_d;
  logic        req0, req1;
  logic        sel, sel_req, gnt_any;

`ifdef NAIVE_ARB_RR_EN
  logic        last_gnt_q, last_gnt_d;
`else
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0]  starve_cnt_q, starve_cnt_d;
`endif

  assign req0 = m0_rd_req | m0_wr_req;
  assign req1 = m1_rd_req | m1_wr_req;

  // A held master keeps the slave until it is granted or withdraws, so the
  // slave never sees its address change while it is inserting wait states.
  always_comb begin
    sel = 1'b0;
    if (hold_q == HOLD_M0 && req0) begin
      sel = 1'b0;
    end else if (hold_q == HOLD_M1 && req1) begin
      sel = 1'b1;
    end else if (req0 && req1) begin
`ifdef NAIVE_ARB_RR_EN
      sel = ~last_gnt_q;
`else
      sel = (starve_cnt_q == LIMIT);
`endif
    end else begin
      sel = req1;
    end
  end

  assign sel_req = sel ? req1 : req0;

  // Read wins over a simultaneous write from the same master.
  always_comb begin
    s_rd_req  = 1'b0;
    s_wr_req  = 1'b0;
    s_rd_addr = 32'h0;
    s_wr_addr = 32'h0;
    s_wr_byte = 4'h0;
    s_wr_data = 32'h0;
    if (!sel && req0) begin
      s_rd_req  = m0_rd_req;
      s_wr_req  = m0_wr_req & ~m0_rd_req;
      s_rd_addr = m0_rd_addr;
      s_wr_addr = m0_wr_addr;
      s_wr_byte = m0_wr_byte;
      s_wr_data = m0_wr_data;
    end else if (sel && req1) begin
      s_rd_req  = m1_rd_req;
      s_wr_req  = m1_wr_req & ~m1_rd_req;
      s_rd_addr = m1_rd_addr;
      s_wr_addr = m1_wr_addr;
      s_wr_byte = m1_wr_byte;
      s_wr_data = m1_wr_data;
    end
  end

  assign m0_rd_gnt = ~sel & s_rd_req & s_rd_gnt;
  assign m1_rd_gnt =  sel & s_rd_req & s_rd_gnt;
  assign m0_wr_gnt = ~sel & s_wr_req & s_wr_gnt;
  assign m1_wr_gnt =  sel & s_wr_req & s_wr_gnt;
  assign gnt_any   = (s_rd_req & s_rd_gnt) | (s_wr_req & s_wr_gnt);

  assign m0_rd_data = (rd_pend_q && !rd_owner_q) ? s_rd_data : 32'h0;
  assign m1_rd_data = (rd_pend_q &&  rd_owner_q) ? s_rd_data : 32'h0;

  always_comb begin
    hold_d     = HOLD_NONE;
    rd_pend_d  = s_rd_req & s_rd_gnt;
    rd_owner_d = sel;
    if (sel_req && !gnt_any) begin
      hold_d = sel ? HOLD_M1 : HOLD_M0;
    end
  end

`ifdef NAIVE_ARB_RR_EN
  assign last_gnt_d = gnt_any ? sel : last_gnt_q;
`else
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!req1 || m1_rd_gnt || m1_wr_gnt) begin
      starve_cnt_d = 8'h0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= HOLD_NONE;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
`ifdef NAIVE_ARB_RR_EN
      last_gnt_q   <= 1'b0;
`else
      starve_cnt_q <= 8'h0;
`endif
    end else begin
      hold_q       <= hold_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
`ifdef NAIVE_ARB_RR_EN
      last_gnt_q   <= last_gnt_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_naive_bus_arbiter2.sv
// Bench for naive_bus_arbiter2: directed vector table, hand sequences for
// wait-state hold / reset / starvation (or round-robin), then random traffic.
module tb_naive_bus_arbiter2;

  localparam int SL = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        rd_req [2];
  logic        wr_req [2];
  logic [31:0] rd_addr[2];
  logic [31:0] wr_addr[2];
  logic [3:0]  wr_byte[2];
  logic [31:0] wr_data[2];
  logic [1:0]  rd_gnt;
  logic [1:0]  wr_gnt;
  logic [31:0] rd_data[2];
  logic        s_rd_req, s_wr_req, s_rd_gnt, s_wr_gnt;
  logic [31:0] s_rd_addr, s_wr_addr, s_wr_data, s_rd_data;
  logic [3:0]  s_wr_byte;

  naive_bus_arbiter2 #(.STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_rd_req(rd_req[0]), .m1_rd_req(rd_req[1]),
    .m0_rd_gnt(rd_gnt[0]), .m1_rd_gnt(rd_gnt[1]),
    .m0_rd_addr(rd_addr[0]), .m1_rd_addr(rd_addr[1]),
    .m0_rd_data(rd_data[0]), .m1_rd_data(rd_data[1]),
    .m0_wr_req(wr_req[0]), .m1_wr_req(wr_req[1]),
    .m0_wr_gnt(wr_gnt[0]), .m1_wr_gnt(wr_gnt[1]),
    .m0_wr_addr(wr_addr[0]), .m1_wr_addr(wr_addr[1]),
    .m0_wr_byte(wr_byte[0]), .m1_wr_byte(wr_byte[1]),
    .m0_wr_data(wr_data[0]), .m1_wr_data(wr_data[1]),
    .s_rd_req(s_rd_req), .s_wr_req(s_wr_req),
    .s_rd_gnt(s_rd_gnt), .s_wr_gnt(s_wr_gnt),
    .s_rd_addr(s_rd_addr), .s_wr_addr(s_wr_addr),
    .s_wr_byte(s_wr_byte), .s_wr_data(s_wr_data),
    .s_rd_data(s_rd_data)
  );

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic        s_rd_req;
    logic        s_wr_req;
    logic [31:0] s_rd_addr;
    logic [31:0] s_wr_addr;
    logic [3:0]  s_wr_byte;
    logic [31:0] s_wr_data;
    logic [1:0]  rd_gnt;
    logic [1:0]  wr_gnt;
    logic [31:0] rd_data0;
    logic [31:0] rd_data1;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".s_rd_req"},   32'(s_rd_req),   32'(e.s_rd_req));
    chk({tag, ".s_wr_req"},   32'(s_wr_req),   32'(e.s_wr_req));
    chk({tag, ".s_rd_addr"},  s_rd_addr,       e.s_rd_addr);
    chk({tag, ".s_wr_addr"},  s_wr_addr,       e.s_wr_addr);
    chk({tag, ".s_wr_byte"},  32'(s_wr_byte),  32'(e.s_wr_byte));
    chk({tag, ".s_wr_data"},  s_wr_data,       e.s_wr_data);
    chk({tag, ".rd_gnt"},     32'(rd_gnt),     32'(e.rd_gnt));
    chk({tag, ".wr_gnt"},     32'(wr_gnt),     32'(e.wr_gnt));
    chk({tag, ".m0_rd_data"}, rd_data[0],      e.rd_data0);
    chk({tag, ".m1_rd_data"}, rd_data[1],      e.rd_data1);
  endtask

  // ---------------- reference model ----------------
  // Arbitration expressed as rules over the bench's own record of who is
  // waiting, how long m1 has starved and whose read returns next.
  bit m_hold;
  int m_held, m_starve, m_owner, m_last, m_sel;
  bit m_pend;

  task automatic model_reset();
    m_hold = 0; m_held = 0; m_starve = 0; m_pend = 0; m_owner = 0; m_last = 0; m_sel = 0;
  endtask

  function automatic exp_t model_eval();
    exp_t e;
    bit   r[2];
    int   s;
    e = '0;
    for (int i = 0; i < 2; i++) r[i] = rd_req[i] | wr_req[i];
    if (m_hold && r[m_held]) s = m_held;
    else if (r[0] && r[1]) begin
`ifdef NAIVE_ARB_RR_EN
      s = 1 - m_last;
`else
      s = (m_starve == SL) ? 1 : 0;
`endif
    end else s = r[1] ? 1 : 0;
    m_sel = s;
    if (r[s]) begin
      e.s_rd_req  = rd_req[s];
      e.s_wr_req  = wr_req[s] & ~rd_req[s];
      e.s_rd_addr = rd_addr[s];
      e.s_wr_addr = wr_addr[s];
      e.s_wr_byte = wr_byte[s];
      e.s_wr_data = wr_data[s];
    end
    e.rd_gnt[s] = e.s_rd_req & s_rd_gnt;
    e.wr_gnt[s] = e.s_wr_req & s_wr_gnt;
    if (m_pend) begin
      if (m_owner == 0) e.rd_data0 = s_rd_data;
      else              e.rd_data1 = s_rd_data;
    end
    return e;
  endfunction

  task automatic model_update();
    exp_t e;
    bit   g, req_sel, req1;
    e       = model_eval();
    g       = e.rd_gnt[m_sel] | e.wr_gnt[m_sel];
    req_sel = rd_req[m_sel] | wr_req[m_sel];
    req1    = rd_req[1] | wr_req[1];
    m_hold  = req_sel && !g;
    m_held  = m_sel;
`ifdef NAIVE_ARB_RR_EN
    m_starve = 0;
`else
    if (!req1 || (g && m_sel == 1)) m_starve = 0;
    else if (m_starve < SL) m_starve++;
`endif
    if (g) m_last = m_sel;
    m_pend  = e.rd_gnt[m_sel];
    m_owner = m_sel;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      rd_req[i] = 1'b0; wr_req[i] = 1'b0; rd_addr[i] = 32'h0;
      wr_addr[i] = 32'h0; wr_byte[i] = 4'h0; wr_data[i] = 32'h0;
    end
    s_rd_gnt = 1'b0; s_wr_gnt = 1'b0; s_rd_data = 32'h0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  rd, wr;      // bit i = master i
    logic [31:0] a0, a1;      // used as both rd and wr address
    logic [3:0]  b0;
    logic        rg, wg;
    logic [31:0] rdata;
    logic        e_rd_req, e_wr_req;
    logic [31:0] e_rd_addr, e_wr_addr;
    logic [3:0]  e_byte;
    logic [3:0]  e_gnt;       // {m1_wr, m1_rd, m0_wr, m0_rd}
    logic [31:0] e_d0, e_d1;
  } vec_t;

  vec_t tbl[12];
  exp_t ev;
  exp_t zero_e;
  logic exp1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_e = '0;
    // idle / single master / contention / alternating reads / rd+wr same master
    tbl[0]  = '{2'b00, 2'b00, 32'h0,   32'h0,    4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0,   32'h0,    4'h0, 4'b0000, 32'h0, 32'h0};
    tbl[1]  = '{2'b10, 2'b00, 32'h0,   32'h1000, 4'h0, 1'b1, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h1000, 32'h1000, 4'h0, 4'b0100, 32'h0, 32'h0};
    tbl[2]  = '{2'b00, 2'b00, 32'h0,   32'h0,    4'h0, 1'b0, 1'b0, 32'hDEAD_BEEF,
                1'b0, 1'b0, 32'h0,   32'h0,    4'h0, 4'b0000, 32'h0, 32'hDEAD_BEEF};
    tbl[3]  = '{2'b10, 2'b01, 32'h10,  32'h20,   4'h3, 1'b1, 1'b1, 32'h0,
                1'b0, 1'b1, 32'h10,  32'h10,   4'h3, 4'b0010, 32'h0, 32'h0};
    tbl[4]  = '{2'b10, 2'b00, 32'h0,   32'h20,   4'h0, 1'b1, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h20,  32'h20,   4'h0, 4'b0100, 32'h0, 32'h0};
    tbl[5]  = '{2'b01, 2'b00, 32'h100, 32'h0,    4'h0, 1'b1, 1'b0, 32'h77,
                1'b1, 1'b0, 32'h100, 32'h100,  4'h0, 4'b0001, 32'h0, 32'h77};
    tbl[6]  = '{2'b10, 2'b00, 32'h0,   32'h104,  4'h0, 1'b1, 1'b0, 32'h1,
                1'b1, 1'b0, 32'h104, 32'h104,  4'h0, 4'b0100, 32'h1, 32'h0};
    tbl[7]  = '{2'b01, 2'b00, 32'h108, 32'h0,    4'h0, 1'b1, 1'b0, 32'h2,
                1'b1, 1'b0, 32'h108, 32'h108,  4'h0, 4'b0001, 32'h0, 32'h2};
    tbl[8]  = '{2'b00, 2'b00, 32'h0,   32'h0,    4'h0, 1'b0, 1'b0, 32'h3,
                1'b0, 1'b0, 32'h0,   32'h0,    4'h0, 4'b0000, 32'h3, 32'h0};
    tbl[9]  = '{2'b00, 2'b00, 32'h0,   32'h0,    4'h0, 1'b0, 1'b0, 32'h55,
                1'b0, 1'b0, 32'h0,   32'h0,    4'h0, 4'b0000, 32'h0, 32'h0};
    tbl[10] = '{2'b01, 2'b01, 32'h200, 32'h0,    4'hF, 1'b1, 1'b1, 32'h0,
                1'b1, 1'b0, 32'h200, 32'h200,  4'hF, 4'b0001, 32'h0, 32'h0};
    tbl[11] = '{2'b00, 2'b00, 32'h0,   32'h0,    4'h0, 1'b0, 1'b0, 32'h9,
                1'b0, 1'b0, 32'h0,   32'h0,    4'h0, 4'b0000, 32'h9, 32'h0};

    // ---- reset ----
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    settle();
    chk_all("in_reset", zero_e);
    @(posedge clk);
    #1 rst_n = 1'b1;
    settle();
    chk_all("after_reset", zero_e);
    tick();

    // ---- table ----
    for (int k = 0; k < 12; k++) begin
      clear_inputs();
      for (int i = 0; i < 2; i++) begin
        rd_req[i] = tbl[k].rd[i];
        wr_req[i] = tbl[k].wr[i];
      end
      rd_addr[0] = tbl[k].a0; wr_addr[0] = tbl[k].a0; wr_byte[0] = tbl[k].b0;
      rd_addr[1] = tbl[k].a1; wr_addr[1] = tbl[k].a1;
      s_rd_gnt = tbl[k].rg; s_wr_gnt = tbl[k].wg; s_rd_data = tbl[k].rdata;
      ev = '0;
      ev.s_rd_req  = tbl[k].e_rd_req;
      ev.s_wr_req  = tbl[k].e_wr_req;
      ev.s_rd_addr = tbl[k].e_rd_addr;
      ev.s_wr_addr = tbl[k].e_wr_addr;
      ev.s_wr_byte = tbl[k].e_byte;
      ev.rd_gnt    = {tbl[k].e_gnt[2], tbl[k].e_gnt[0]};
      ev.wr_gnt    = {tbl[k].e_gnt[3], tbl[k].e_gnt[1]};
      ev.rd_data0  = tbl[k].e_d0;
      ev.rd_data1  = tbl[k].e_d1;
      settle();
      chk_all($sformatf("vec%0d", k), ev);
      tick();
    end

    // ---- wait-state hold: m1 read stalled 3 cycles, m0 arrives in cycle 2 ----
    clear_inputs();
    rd_req[1] = 1'b1; rd_addr[1] = 32'h40;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin rd_req[0] = 1'b1; rd_addr[0] = 32'h50; end
      settle();
      chk($sformatf("hold%0d.s_rd_addr", c), s_rd_addr, 32'h40);
      chk($sformatf("hold%0d.rd_gnt", c), 32'(rd_gnt), 32'h0);
      tick();
    end
    s_rd_gnt = 1'b1;
    settle();
    chk("hold_gnt.s_rd_addr", s_rd_addr, 32'h40);
    chk("hold_gnt.rd_gnt", 32'(rd_gnt), 32'h2);
    tick();
    rd_req[1] = 1'b0; s_rd_data = 32'h4040;
    settle();
    chk("hold_next.s_rd_addr", s_rd_addr, 32'h50);
    chk("hold_next.rd_gnt", 32'(rd_gnt), 32'h1);
    chk("hold_next.m1_rd_data", rd_data[1], 32'h4040);
    chk("hold_next.m0_rd_data", rd_data[0], 32'h0);
    tick();

    // ---- reset while a read return is pending ----
    clear_inputs();
    rd_req[0] = 1'b1; rd_addr[0] = 32'h300; s_rd_gnt = 1'b1;
    settle();
    chk("rst_pre.rd_gnt", 32'(rd_gnt), 32'h1);
    tick();
    #2 rst_n = 1'b0;
    clear_inputs();
    s_rd_data = 32'hBAD0_BAD0;
    model_reset();
    settle();
    chk("rst_mid.m0_rd_data", rd_data[0], 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    settle();
    chk("rst_post.m0_rd_data", rd_data[0], 32'h0);
    chk("rst_post.m1_rd_data", rd_data[1], 32'h0);
    chk("rst_post.rd_gnt", 32'(rd_gnt), 32'h0);
    tick();

    // ---- continuous contention from a fresh reset ----
    rd_req[0] = 1'b1; rd_req[1] = 1'b1;
    rd_addr[0] = 32'hA0; rd_addr[1] = 32'hB0; s_rd_gnt = 1'b1; s_rd_data = 32'h0;
    for (int k = 0; k < 2 * (SL + 1); k++) begin
`ifdef NAIVE_ARB_RR_EN
      exp1 = (k % 2) == 0;
`else
      exp1 = (k % (SL + 1)) == SL;
`endif
      settle();
      chk($sformatf("contend%0d.m1_rd_gnt", k), 32'(rd_gnt[1]), 32'(exp1));
      chk($sformatf("contend%0d.m0_rd_gnt", k), 32'(rd_gnt[0]), 32'(!exp1));
      tick();
    end
    clear_inputs();
    settle();
    tick();

    // ---- random traffic against the model ----
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        rd_req[i]  = ($urandom_range(0, 99) < 40);
        wr_req[i]  = ($urandom_range(0, 99) < 35);
        rd_addr[i] = $urandom;
        wr_addr[i] = $urandom;
        wr_byte[i] = 4'($urandom_range(0, 15));
        wr_data[i] = $urandom;
      end
      s_rd_gnt  = 1'b0;
      s_wr_gnt  = 1'b0;
      s_rd_data = $urandom;
      ev = model_eval();
      s_rd_gnt = ev.s_rd_req & ($urandom_range(0, 99) < 70);
      s_wr_gnt = ev.s_wr_req & ($urandom_range(0, 99) < 70);
      settle();
      ev = model_eval();
      chk_all($sformatf("rand%0d", n), ev);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
